// File: rtl/id_ex_ctrl_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_ctrl_skid_reg
// Brief    : ID->EX ALU-control pipeline register, valid/ready on both sides,
//            flush-to-bubble, optional 2-entry skid, occupancy and stall count.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_ctrl_skid_reg #(
    parameter int ALU_OP_WIDTH    = 7,
    parameter int ALU_FUNC3_WIDTH = 3,
    parameter int ALU_FUNC7_WIDTH = 7,
    parameter bit SKID_EN         = 1'b1,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       alu_src_in,
    input  logic [ALU_OP_WIDTH-1:0]    alu_op_in,
    input  logic [ALU_FUNC3_WIDTH-1:0] alu_func3_in,
    input  logic [ALU_FUNC7_WIDTH-1:0] alu_func7_in,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       alu_src_out,
    output logic [ALU_OP_WIDTH-1:0]    alu_op_out,
    output logic [ALU_FUNC3_WIDTH-1:0] alu_func3_out,
    output logic [ALU_FUNC7_WIDTH-1:0] alu_func7_out,
    output logic [1:0]                 occupancy,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    localparam int c_W       = 1 + ALU_OP_WIDTH + ALU_FUNC3_WIDTH + ALU_FUNC7_WIDTH;
    localparam int c_F3_LSB  = ALU_FUNC7_WIDTH;
    localparam int c_OP_LSB  = ALU_FUNC7_WIDTH + ALU_FUNC3_WIDTH;
    localparam int c_SRC_BIT = c_W - 1;

    logic [c_W-1:0]             w_in;
    logic [c_W-1:0]             w_s;
    logic [c_W-1:0]             r_m;
    logic                       r_mv;
    logic                       w_sv;
    logic                       w_accept;
    logic                       w_drain;
    logic [STALL_CNT_WIDTH-1:0] r_stall;

    assign w_in     = {alu_src_in, alu_op_in, alu_func3_in, alu_func7_in};
    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_mv & out_ready;

    generate
        if (SKID_EN) begin : g_skid
            logic [c_W-1:0] r_s;
            logic           r_sv;

            assign in_ready = ~reset & ~r_sv;
            assign w_s      = r_s;
            assign w_sv     = r_sv;

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    r_sv <= 1'b0;
                    r_s  <= '0;
                end else if (r_mv && !r_sv && !w_drain && w_accept) begin
                    r_sv <= 1'b1;
                    r_s  <= w_in;
                end else if (r_sv && w_drain) begin
                    r_sv <= 1'b0;
                end
            end
        end else begin : g_noskid
            assign in_ready = ~reset & (~r_mv | out_ready);
            assign w_s      = '0;
            assign w_sv     = 1'b0;
        end
    endgenerate

    // Main entry; skid entry refills it when the held beat drains.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_mv <= 1'b0;
            r_m  <= '0;
        end else if (!r_mv) begin
            if (w_accept) begin
                r_mv <= 1'b1;
                r_m  <= w_in;
            end
        end else if (w_sv) begin
            if (w_drain) begin
                r_m <= w_s;
            end
        end else if (w_drain) begin
            if (w_accept) begin
                r_m <= w_in;
            end else begin
                r_mv <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall <= '0;
        end else if (r_mv && !out_ready && (r_stall != {STALL_CNT_WIDTH{1'b1}})) begin
            r_stall <= r_stall + STALL_CNT_WIDTH'(1);
        end
    end

    assign out_valid     = r_mv;
    assign alu_src_out   = r_mv ? r_m[c_SRC_BIT] : 1'b0;
    assign alu_op_out    = r_mv ? r_m[c_OP_LSB +: ALU_OP_WIDTH] : '0;
    assign alu_func3_out = r_mv ? r_m[c_F3_LSB +: ALU_FUNC3_WIDTH] : '0;
    assign alu_func7_out = r_mv ? r_m[0 +: ALU_FUNC7_WIDTH] : '0;
    assign occupancy     = {1'b0, r_mv} + {1'b0, w_sv};
    assign stall_cycles  = r_stall;

endmodule
`default_nettype wire
